bus_fifo_device: RTL and testbench

BUS_FIFO_DEVICE -- requirements
Module: bus_fifo_device

---
 rtl/bus_fifo_device.sv | 222 ++++++++++++++++++++++
 tb/tb_bus_fifo_device.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_device.sv
// bus_fifo_device
//   Memory-mapped device with a TX FIFO drained by a valid/ready stream and
//   an RX FIFO filled by a valid/ready stream. Register map (addr_in[3:2]):
//     0 TXDATA  write pushes TX FIFO, read returns 0
//     1 RXDATA  read pops RX FIFO, write ignored
//     2 STATUS  flags/counts, bits 4/5 are write-1-to-clear sticky errors
//     3 CTRL    bit0 irq_en (rw), bit1 write-1 flushes both FIFOs
// Ports:
//   clk_in, reset_in                  clock, asynchronous active-high reset
//   req_in, addr_in, we_in, wdata_in  single-cycle bus request, never stalled
//   rdata_out                         registered read response (cycle N+1)
//   tx_valid_out, tx_data_out, tx_ready_in   TX drain stream
//   rx_valid_in, rx_data_in, rx_ready_out    RX fill stream
//   irq_out                           level interrupt
module bus_fifo_device #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int Depth        = 4
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    req_in,
  input  logic [AddressWidth-1:0] addr_in,
  input  logic                    we_in,
  input  logic [DataWidth-1:0]    wdata_in,
  output logic [DataWidth-1:0]    rdata_out,
  output logic                    tx_valid_out,
  output logic [DataWidth-1:0]    tx_data_out,
  input  logic                    tx_ready_in,
  input  logic                    rx_valid_in,
  input  logic [DataWidth-1:0]    rx_data_in,
  output logic                    rx_ready_out,
  output logic                    irq_out
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_RXDATA = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Storage and state
  logic [DataWidth-1:0] tx_mem_r [Depth];
  logic [DataWidth-1:0] rx_mem_r [Depth];
  logic [PtrW-1:0]      tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CntW-1:0]      tx_count_r, rx_count_r;
  logic                 overflow_r, underflow_r, irq_en_r;
  logic [DataWidth-1:0] rdata_r;

  // Decoded controls
  logic [1:0]           sel_s;
  logic                 rd_s, wr_s;
  logic                 tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic                 tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic                 ovf_set_s, unf_set_s, status_wr_s, ctrl_wr_s, flush_s;
  logic [7:0]           tx_cnt8_s, rx_cnt8_s;
  logic [DataWidth-1:0] status_s, rdata_nxt_s;
  logic                 addr_unused_s;

  // Address bits outside [3:2] are intentionally not decoded.
  assign addr_unused_s = ^{addr_in[AddressWidth-1:4], addr_in[1:0]};

  assign sel_s = addr_in[3:2];
  assign rd_s  = req_in && !we_in;
  assign wr_s  = req_in && we_in;

  // Flags come from start-of-cycle counts, so same-cycle stream activity
  // never rescues a full write or an empty read.
  assign tx_empty_s = (tx_count_r == CntW'(0));
  assign tx_full_s  = (tx_count_r == CntW'(Depth));
  assign rx_empty_s = (rx_count_r == CntW'(0));
  assign rx_full_s  = (rx_count_r == CntW'(Depth));

  assign tx_push_s   = wr_s && (sel_s == ADDR_TXDATA) && !tx_full_s;
  assign ovf_set_s   = wr_s && (sel_s == ADDR_TXDATA) && tx_full_s;
  assign tx_pop_s    = !tx_empty_s && tx_ready_in;
  assign rx_push_s   = rx_valid_in && !rx_full_s;
  assign rx_pop_s    = rd_s && (sel_s == ADDR_RXDATA) && !rx_empty_s;
  assign unf_set_s   = rd_s && (sel_s == ADDR_RXDATA) && rx_empty_s;
  assign status_wr_s = wr_s && (sel_s == ADDR_STATUS);
  assign ctrl_wr_s   = wr_s && (sel_s == ADDR_CTRL);
  assign flush_s     = ctrl_wr_s && wdata_in[1];

  assign tx_valid_out = !tx_empty_s;
  assign tx_data_out  = tx_mem_r[tx_rd_ptr_r];
  assign rx_ready_out = !rx_full_s;
  assign rdata_out    = rdata_r;
  assign irq_out      = irq_en_r && (!rx_empty_s || overflow_r || underflow_r);

  assign tx_cnt8_s = 8'(tx_count_r);
  assign rx_cnt8_s = 8'(rx_count_r);

  // STATUS register image
  always_comb begin
    status_s        = '0;
    status_s[0]     = tx_empty_s;
    status_s[1]     = tx_full_s;
    status_s[2]     = rx_empty_s;
    status_s[3]     = rx_full_s;
    status_s[4]     = overflow_r;
    status_s[5]     = underflow_r;
    status_s[15:8]  = tx_cnt8_s;
    status_s[23:16] = rx_cnt8_s;
  end

  // Read response mux; anything other than an accepted read yields 0
  always_comb begin
    rdata_nxt_s = '0;
    if (rd_s) begin
      case (sel_s)
        ADDR_TXDATA: rdata_nxt_s = '0;
        ADDR_RXDATA: begin
          if (!rx_empty_s) begin
            rdata_nxt_s = rx_mem_r[rx_rd_ptr_r];
          end else begin
            rdata_nxt_s = '0;
          end
        end
        ADDR_STATUS: rdata_nxt_s = status_s;
        ADDR_CTRL:   rdata_nxt_s = {{(DataWidth-1){1'b0}}, irq_en_r};
        default:     rdata_nxt_s = '0;
      endcase
    end else begin
      rdata_nxt_s = '0;
    end
  end

  // TX FIFO: bus push, stream pop, flush wins over both
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < Depth; i++) tx_mem_r[i] <= '0;
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_count_r  <= '0;
    end else if (flush_s) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_count_r  <= '0;
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_ptr_r] <= wdata_in;
        tx_wr_ptr_r           <= tx_wr_ptr_r + PtrW'(1);
      end
      if (tx_pop_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + PtrW'(1);
      end
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + CntW'(1);
        2'b01:   tx_count_r <= tx_count_r - CntW'(1);
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // RX FIFO: stream push, bus pop, flush wins over both
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < Depth; i++) rx_mem_r[i] <= '0;
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      rx_count_r  <= '0;
    end else if (flush_s) begin
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      rx_count_r  <= '0;
    end else begin
      if (rx_push_s) begin
        rx_mem_r[rx_wr_ptr_r] <= rx_data_in;
        rx_wr_ptr_r           <= rx_wr_ptr_r + PtrW'(1);
      end
      if (rx_pop_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + PtrW'(1);
      end
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + CntW'(1);
        2'b01:   rx_count_r <= rx_count_r - CntW'(1);
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Sticky error flags (set wins over a same-cycle clear) and irq enable
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      irq_en_r    <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (status_wr_s && wdata_in[4]) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (unf_set_s) begin
        underflow_r <= 1'b1;
      end else if (status_wr_s && wdata_in[5]) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
      if (ctrl_wr_s) begin
        irq_en_r <= wdata_in[0];
      end else begin
        irq_en_r <= irq_en_r;
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rdata_r <= '0;
    end else begin
      rdata_r <= rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_bus_fifo_device.sv
// Bench for bus_fifo_device (DataWidth=32, Depth=4): a register-level vector
// table followed by hand-written stream and reset sequences. Read responses
// and emitted TX words are checked against scoreboard queues.
module tb_bus_fifo_device;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        req_in, we_in;
  logic [31:0] addr_in, wdata_in, rdata_out;
  logic        tx_valid_out, tx_ready_in, rx_valid_in, rx_ready_out, irq_out;
  logic [31:0] tx_data_out, rx_data_in;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rd_q[$];   // expected bus responses
  logic [31:0] tx_q[$];   // expected TX stream words
  logic [31:0] obs_q[$];  // observed TX stream words

  bus_fifo_device #(.DataWidth(32), .AddressWidth(32), .Depth(4)) dut (
    .clk_in(clk), .reset_in(reset_in),
    .req_in(req_in), .addr_in(addr_in), .we_in(we_in), .wdata_in(wdata_in),
    .rdata_out(rdata_out),
    .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out), .tx_ready_in(tx_ready_in),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in), .rx_ready_out(rx_ready_out),
    .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  // Capture every TX handshake mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!reset_in && tx_valid_out && tx_ready_in) obs_q.push_back(tx_data_out);
  end

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; the expected response (0 for writes) goes to the scoreboard.
  task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] d,
                     input logic [31:0] exp);
    logic [31:0] e;
    req_in = 1'b1; addr_in = {28'h0, a, 2'b00}; we_in = w; wdata_in = d;
    rd_q.push_back(w ? 32'h0 : exp);
    tick();
    req_in = 1'b0; addr_in = 32'h0; we_in = 1'b0; wdata_in = 32'h0;
    e = rd_q.pop_front();
    chk("rdata", rdata_out, e);
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_valid_in = 1'b1; rx_data_in = d;
    tick();
    rx_valid_in = 1'b0; rx_data_in = 32'h0;
  endtask

  // Wait (bounded) for the expected TX words, then compare in order.
  task automatic cmp_stream(input string nm);
    for (int i = 0; i < 20 && obs_q.size() < tx_q.size(); i++) tick();
    repeat (3) tick();
    chk({nm, "_count"}, obs_q.size(), tx_q.size());
    while (tx_q.size() > 0 && obs_q.size() > 0) chk(nm, obs_q.pop_front(), tx_q.pop_front());
    tx_q.delete();
    obs_q.delete();
  endtask

  initial begin
    reset_in = 1'b1; req_in = 1'b0; we_in = 1'b0; addr_in = 32'h0; wdata_in = 32'h0;
    tx_ready_in = 1'b0; rx_valid_in = 1'b0; rx_data_in = 32'h0;

    tbl[0]  = '{2'd2, 1'b0, 32'h0,    32'h0000_0005, 1'b0};
    tbl[1]  = '{2'd0, 1'b1, 32'h11,   32'h0, 1'b0};
    tbl[2]  = '{2'd0, 1'b1, 32'h12,   32'h0, 1'b0};
    tbl[3]  = '{2'd0, 1'b1, 32'h13,   32'h0, 1'b0};
    tbl[4]  = '{2'd0, 1'b1, 32'h14,   32'h0, 1'b0};
    tbl[5]  = '{2'd0, 1'b1, 32'h15,   32'h0, 1'b0};
    tbl[6]  = '{2'd2, 1'b0, 32'h0,    32'h0000_0416, 1'b0};
    tbl[7]  = '{2'd0, 1'b0, 32'h0,    32'h0, 1'b0};
    tbl[8]  = '{2'd2, 1'b1, 32'h10,   32'h0, 1'b0};
    tbl[9]  = '{2'd2, 1'b0, 32'h0,    32'h0000_0406, 1'b0};
    tbl[10] = '{2'd3, 1'b1, 32'h1,    32'h0, 1'b0};
    tbl[11] = '{2'd3, 1'b0, 32'h0,    32'h1, 1'b0};
    tbl[12] = '{2'd1, 1'b1, 32'hDEAD, 32'h0, 1'b0};
    tbl[13] = '{2'd2, 1'b0, 32'h0,    32'h0000_0406, 1'b0};
    tbl[14] = '{2'd1, 1'b0, 32'h0,    32'h0, 1'b1};
    tbl[15] = '{2'd2, 1'b0, 32'h0,    32'h0000_0426, 1'b1};
    tbl[16] = '{2'd2, 1'b1, 32'h20,   32'h0, 1'b0};
    tbl[17] = '{2'd2, 1'b0, 32'h0,    32'h0000_0406, 1'b0};
    tbl[18] = '{2'd3, 1'b1, 32'h2,    32'h0, 1'b0};
    tbl[19] = '{2'd2, 1'b0, 32'h0,    32'h0000_0005, 1'b0};
    tbl[20] = '{2'd3, 1'b0, 32'h0,    32'h0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid_out}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready_out}, 32'h1);
    chk("rst_irq", {31'h0, irq_out}, 32'h0);
    reset_in = 1'b0;
    tick();

    // Register-level table, TX stream held off
    for (int i = 0; i < 21; i++) begin
      bus(tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_irq", i), {31'h0, irq_out}, {31'h0, tbl[i].exp_irq});
    end
    cmp_stream("tbl_tx");

    // Two words streamed straight out in order
    tx_ready_in = 1'b1;
    tx_q.push_back(32'hA1); bus(2'd0, 1'b1, 32'hA1, 32'h0);
    tx_q.push_back(32'hA2); bus(2'd0, 1'b1, 32'hA2, 32'h0);
    cmp_stream("tx_a");
    chk("tx_a_idle", {31'h0, tx_valid_out}, 32'h0);

    // Five writes into a depth-4 FIFO: fifth dropped and never emitted
    tx_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tx_q.push_back(32'h21 + 32'(i));
      bus(2'd0, 1'b1, 32'h21 + 32'(i), 32'h0);
    end
    bus(2'd2, 1'b0, 32'h0, 32'h0000_0416);
    tx_ready_in = 1'b1;
    cmp_stream("tx_ovf");
    bus(2'd2, 1'b1, 32'h10, 32'h0);

    // Full write is dropped even though the stream pops that same cycle
    tx_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(32'hB1 + 32'(i));
      bus(2'd0, 1'b1, 32'hB1 + 32'(i), 32'h0);
    end
    tx_ready_in = 1'b1;
    bus(2'd0, 1'b1, 32'hB5, 32'h0);
    bus(2'd2, 1'b0, 32'h0, 32'h0000_0314);
    cmp_stream("tx_full_pop");
    bus(2'd2, 1'b1, 32'h10, 32'h0);
    tx_ready_in = 1'b0;

    // RX read, then underflow and W1C clear
    rx_push(32'h55);
    bus(2'd1, 1'b0, 32'h0, 32'h55);
    bus(2'd1, 1'b0, 32'h0, 32'h0);
    bus(2'd2, 1'b0, 32'h0, 32'h0000_0025);
    bus(2'd2, 1'b1, 32'h20, 32'h0);
    bus(2'd2, 1'b0, 32'h0, 32'h0000_0005);

    // Empty read returns 0 while a same-cycle stream push is retained
    rx_valid_in = 1'b1; rx_data_in = 32'h99;
    bus(2'd1, 1'b0, 32'h0, 32'h0);
    rx_valid_in = 1'b0; rx_data_in = 32'h0;
    bus(2'd1, 1'b0, 32'h0, 32'h99);
    bus(2'd2, 1'b1, 32'h20, 32'h0);

    // Interrupt follows RX occupancy
    bus(2'd3, 1'b1, 32'h1, 32'h0);
    chk("irq_idle", {31'h0, irq_out}, 32'h0);
    rx_push(32'h77);
    chk("irq_rx", {31'h0, irq_out}, 32'h1);
    bus(2'd1, 1'b0, 32'h0, 32'h77);
    chk("irq_pop", {31'h0, irq_out}, 32'h0);

    // Fill both FIFOs, then flush while keeping irq_en
    for (int i = 0; i < 4; i++) bus(2'd0, 1'b1, 32'hC0 + 32'(i), 32'h0);
    for (int i = 0; i < 4; i++) rx_push(32'hD0 + 32'(i));
    chk("full_rx_ready", {31'h0, rx_ready_out}, 32'h0);
    bus(2'd2, 1'b0, 32'h0, 32'h0004_040A);
    bus(2'd3, 1'b1, 32'h3, 32'h0);
    chk("flush_tx_valid", {31'h0, tx_valid_out}, 32'h0);
    chk("flush_irq", {31'h0, irq_out}, 32'h0);
    bus(2'd2, 1'b0, 32'h0, 32'h0000_0005);
    bus(2'd3, 1'b0, 32'h0, 32'h1);

    // Reset with three TX words queued and a read response pending
    for (int i = 0; i < 3; i++) bus(2'd0, 1'b1, 32'hE0 + 32'(i), 32'h0);
    chk("pre_rst_tx_valid", {31'h0, tx_valid_out}, 32'h1);
    req_in = 1'b1; addr_in = 32'h8; we_in = 1'b0;
    @(posedge clk);
    #1;
    req_in = 1'b0; addr_in = 32'h0;
    chk("pre_rst_rdata", rdata_out, 32'h0000_0304);
    reset_in = 1'b1;
    #1;
    chk("mid_rst_tx_valid", {31'h0, tx_valid_out}, 32'h0);
    chk("mid_rst_rdata", rdata_out, 32'h0);
    chk("mid_rst_rx_ready", {31'h0, rx_ready_out}, 32'h1);
    tick();
    reset_in = 1'b0;
    tick();
    bus(2'd2, 1'b0, 32'h0, 32'h0000_0005);
    bus(2'd3, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
